mdio_master: RTL and testbench
==============================

MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10, meaning clk cycles per MDC half-period (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port phy_add  input  5  PHY address of the request.
REQ-005 SHALL have port reg_add  input  5  register address of the request.
REQ-006 SHALL have port wr_data  input  16  write payload.
REQ-007 SHALL have port wren  input  1  write request strobe.
REQ-008 SHALL have port rden  input  1  read request strobe.
REQ-009 SHALL have port busy  output  1  frame in progress; requests are ignored while high.
REQ-010 SHALL have port rd_data  output  16  last read result.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse marking rd_data as updated.
REQ-012 SHALL have port mdc  output  1  management clock to the PHY.
REQ-013 SHALL have ports mdio_o (output, 1), mdio_oe (output, 1) and mdio_i (input, 1), forming the split MDIO pad; the tristate buffer sits outside this block.

Function
REQ-014 SHALL accept a request only in IDLE, on a clk edge where wren or rden is high; phy_add, reg_add, wr_data and the opcode SHALL be latched on that edge.
REQ-015 SHALL treat wren and rden high together as a write.
REQ-016 SHALL assert busy on the cycle after acceptance and hold it until the state returns to IDLE; wren/rden while busy are dropped, not queued.
REQ-017 SHALL derive mdc from a counter producing rise/fall strobes every CLK_DIV clk cycles; mdc period = 2*CLK_DIV clk cycles; mdc idles low.
REQ-018 SHALL change mdio_o/mdio_oe only on mdc falling strobes and sample mdio_i only on mdc rising strobes.
REQ-019 SHALL run the FSM states IDLE -> PRE -> CMD -> TA -> DATA -> DONE -> IDLE, with one bit per mdc period.
REQ-020 PRE SHALL drive 32 ones; CMD SHALL drive 14 bits MSB-first: ST=01, OP (write 01, read 10), phy_add[4:0], reg_add[4:0].
REQ-021 TA SHALL drive 10 for a write; for a read it SHALL set mdio_oe=0 for both TA bits.
REQ-022 DATA SHALL shift wr_data MSB-first for a write; for a read it SHALL keep mdio_oe=0 and shift in 16 bits MSB-first.
REQ-023 DONE SHALL, for a read, load rd_data and pulse rd_valid for exactly one clk; DONE SHALL then drop mdio_oe, hold mdc low and enter IDLE, deasserting busy on the next cycle.
REQ-024 Frame length SHALL be 64 mdc periods (32 without preamble); busy SHALL stay high for frame_length*2*CLK_DIV+2 clk cycles.
REQ-025 rd_data SHALL keep its value across write frames.

Reset
REQ-026 rst SHALL force IDLE and clear the divider; busy=0, rd_valid=0, rd_data=0, mdc=0, mdio_o=1, mdio_oe=0.
REQ-027 rst mid-frame SHALL abort the frame with no rd_valid; the first request after reset SHALL start a full new frame.

Configuration
REQ-028 With macro MDIO_PREAMBLE_EN defined, the PRE state SHALL emit 32 ones; undefined, PRE SHALL be skipped (preamble suppression) and IDLE goes directly to CMD.

Structure
REQ-029 Package mdio_pkg SHALL hold the ST, OP_WR, OP_RD and TA_WR constants, the FSM state enum, and the PRE_BITS/CMD_BITS/DATA_BITS widths.
REQ-030 Sub-module mdc_gen SHALL hold the divider and output mdc, rise_stb and fall_stb.

Verification
REQ-031 CLK_DIV=2, write phy_add=1, reg_add=0, wr_data=0x3100 -> on mdio_o, 32 ones, then 01 01 00001 00000 10 0011000100000000; busy high for 258 clk.
REQ-032 Read phy_add=1, reg_add=2 with the PHY model driving 0x0283 -> mdio_oe=0 from TA through DATA; rd_data=0x0283 with one rd_valid pulse.
REQ-033 wren=rden=1 in the same cycle -> OP bits 01; no rd_valid.
REQ-034 A second wren during busy -> ignored; exactly one frame is observed on mdio_o.
REQ-035 rst asserted at mdc period 40 of a read -> next clk busy=0, mdio_oe=0, mdc=0, no rd_valid.
REQ-036 Build without MDIO_PREAMBLE_EN -> a write frame is 32 mdc periods starting with 01.

Source files
------------

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared constants, FSM state type and helpers for the MDIO master
//
// Holds the clause-22 frame field constants (ST, OP_WR, OP_RD, TA_WR), the
// per-phase bit counts and the FSM state enum. The helpers give the last bit
// index of each serial phase and the phase that follows it.
package mdio_pkg;

  localparam int PRE_BITS  = 32;
  localparam int CMD_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  localparam logic [1:0] ST    = 2'b01;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] TA_WR = 2'b10;

  typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, DONE} mdio_state_e;

  function automatic logic [5:0] last_bit(mdio_state_e s);
    case (s)
      PRE:     last_bit = 6'(PRE_BITS - 1);
      CMD:     last_bit = 6'(CMD_BITS - 1);
      TA:      last_bit = 6'(TA_BITS - 1);
      default: last_bit = 6'(DATA_BITS - 1);
    endcase
  endfunction

  function automatic mdio_state_e next_phase(mdio_state_e s);
    case (s)
      PRE:     next_phase = CMD;
      CMD:     next_phase = TA;
      TA:      next_phase = DATA;
      DATA:    next_phase = DONE;
      default: next_phase = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// rtl/mdio_master_if.sv - request/response bus of the MDIO master
//
// master modport: the requester (drives phy_add, reg_add, wr_data, wren, rden;
//                 sees busy, rd_data, rd_valid)
// slave modport:  the mdio_master block itself
interface mdio_master_if;
  logic [4:0]  phy_add;
  logic [4:0]  reg_add;
  logic [15:0] wr_data;
  logic        wren;
  logic        rden;
  logic        busy;
  logic [15:0] rd_data;
  logic        rd_valid;

  modport master (output phy_add, reg_add, wr_data, wren, rden,
                  input  busy, rd_data, rd_valid);
  modport slave  (input  phy_add, reg_add, wr_data, wren, rden,
                  output busy, rd_data, rd_valid);
endinterface

// File: rtl/mdc_gen.sv
// rtl/mdc_gen.sv - MDC divider with rise/fall strobes
//
// Ports: clk, rst (sync, active-high), en (divider runs while high, otherwise
// cleared with mdc low), mdc (registered clock to the PHY), rise_stb/fall_stb
// (high for the clk cycle whose closing edge raises/lowers mdc).
module mdc_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] cnt;
  logic       tick;

  assign tick     = en && (cnt == 8'(CLK_DIV - 1));
  assign rise_stb = tick && !mdc;
  assign fall_stb = tick && mdc;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - clause-22 MDIO management master (single read/write frames)
//
// Ports: clk, rst (sync, active-high); req (mdio_master_if.slave: request
// fields/strobes in, busy/rd_data/rd_valid out); mdc; split pad mdio_o,
// mdio_oe, mdio_i. Macro MDIO_PREAMBLE_EN enables the 32-bit preamble;
// without it frames start directly with ST.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic         clk,
  input  logic         rst,
  mdio_master_if.slave req,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);

  mdio_state_e state;
  mdio_state_e nxt;
  logic [5:0]  bit_cnt;
  logic        is_rd;
  logic [31:0] tx_sr;
  logic [15:0] rx_sr;
  logic        busy_q;
  logic        rd_valid_q;
  logic [15:0] rd_data_q;
  logic [31:0] frame;
  logic        accept;
  logic        en;
  logic        rise_stb;
  logic        fall_stb;

  // busy still high in the IDLE cycle after DONE, so that cycle never accepts
  assign accept = (state == IDLE) && !busy_q && (req.wren || req.rden);
  assign en     = (state != IDLE) && (state != DONE);

  assign req.busy     = busy_q;
  assign req.rd_valid = rd_valid_q;
  assign req.rd_data  = rd_data_q;

  // Everything after the preamble; read TA/DATA bits are never driven
  always_comb begin
    frame = '0;
    if (req.wren) frame = {ST, OP_WR, req.phy_add, req.reg_add, TA_WR, req.wr_data};
    else          frame = {ST, OP_RD, req.phy_add, req.reg_add, 18'h3FFFF};
  end

  always_comb begin
    nxt = state;
    if (bit_cnt == last_bit(state)) nxt = next_phase(state);
  end

  mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mdc      (mdc),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      is_rd      <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      mdio_o     <= 1'b1;
      mdio_oe    <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= accept;
          if (accept) begin
            is_rd   <= !req.wren;
            bit_cnt <= '0;
            mdio_oe <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
            state  <= PRE;
            mdio_o <= 1'b1;
            tx_sr  <= frame;
`else
            // first bit goes out now since mdc is low until the first rise
            state  <= CMD;
            mdio_o <= frame[31];
            tx_sr  <= {frame[30:0], 1'b0};
`endif
          end
        end
        DONE: begin
          if (is_rd) begin
            rd_data_q  <= rx_sr;
            rd_valid_q <= 1'b1;
          end
          mdio_oe <= 1'b0;
          mdio_o  <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          if (rise_stb && state == DATA) rx_sr <= {rx_sr[14:0], mdio_i};
          if (fall_stb) begin
            state   <= nxt;
            bit_cnt <= (nxt != state) ? 6'd0 : bit_cnt + 6'd1;
            case (nxt)
              DONE: begin
                mdio_oe <= 1'b0;
                mdio_o  <= 1'b1;
              end
              PRE: begin
                mdio_oe <= 1'b1;
                mdio_o  <= 1'b1;
              end
              default: begin
                mdio_o  <= tx_sr[31];
                tx_sr   <= {tx_sr[30:0], 1'b0};
                mdio_oe <= !(is_rd && (nxt == TA || nxt == DATA));
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - scoreboard bench for mdio_master with a PHY model
module tb_mdio_master;

  localparam int CD = 2;
`ifdef MDIO_PREAMBLE_EN
  localparam int PRE_N = 32;
`else
  localparam int PRE_N = 0;
`endif
  localparam int NBITS    = PRE_N + 32;
  localparam int BUSY_LEN = NBITS * 2 * CD + 2;
  localparam int ABORT_AT = (PRE_N != 0) ? 40 : 20;
  localparam int DATA_OFF = PRE_N + 16;

  typedef struct {
    bit          abort;
    bit          rd;
    logic [63:0] bits;
    logic [63:0] oe;
    logic [15:0] phy_val;
    logic [15:0] rd_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mdc, mdio_o, mdio_oe;
  logic mdio_i = 1'b1;

  mdio_master_if bus ();

  mdio_master #(.CLK_DIV(CD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .mdc     (mdc),
    .mdio_o  (mdio_o),
    .mdio_oe (mdio_oe),
    .mdio_i  (mdio_i)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] last_rd = 16'h0;
  bit          mon_en = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Expected frame built straight from the clause-22 field layout
  task automatic issue(bit wr, bit rd, logic [4:0] pa, logic [4:0] ra,
                       logic [15:0] wd, logic [15:0] pv, bit abort);
    exp_t        e;
    logic [31:0] f;
    logic [63:0] mask;
    int          t = 0;
    while (bus.busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) timeout_fail("idle_wait");
    mask = (64'h1 << NBITS) - 64'h1;
    if (wr) f = {2'b01, 2'b01, pa, ra, 2'b10, wd};
    else    f = {2'b01, 2'b10, pa, ra, 18'h0};
    e.bits    = (PRE_N != 0) ? {32'hFFFF_FFFF, f} : {32'h0, f};
    e.oe      = wr ? mask : (mask & ~64'h3FFFF);
    e.rd      = !wr;
    e.abort   = abort;
    e.phy_val = pv;
    if (!wr && !abort) last_rd = pv;
    e.rd_data = last_rd;
    sb.push_back(e);
    bus.wren    = wr;
    bus.rden    = rd;
    bus.phy_add = pa;
    bus.reg_add = ra;
    bus.wr_data = wd;
    @(negedge clk);
    bus.wren = 1'b0;
    bus.rden = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (bus.busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) timeout_fail("frame_end");
    repeat (2) @(negedge clk);
  endtask

  // Monitor + PHY model: collects each busy window, then pops and compares
  bit          in_frame = 1'b0;
  logic        mdc_prev = 1'b0;
  logic [63:0] cap_o, cap_oe;
  int          nrise, blen, nvalid;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cap_o = '0;
          cap_oe = '0;
          nrise = 0;
          blen = 0;
          nvalid = 0;
        end
        blen++;
        if (bus.rd_valid) nvalid++;
        if (mdc && !mdc_prev) begin
          cap_o  = {cap_o[62:0], mdio_o};
          cap_oe = {cap_oe[62:0], mdio_oe};
          nrise++;
          if (sb.size() > 0 && nrise >= DATA_OFF && nrise < DATA_OFF + 16)
            mdio_i = sb[0].phy_val[15 - (nrise - DATA_OFF)];
          else
            mdio_i = 1'b1;
        end
      end else if (in_frame) begin
        exp_t e;
        in_frame = 1'b0;
        mdio_i = 1'b1;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got a frame with %0d mdc periods, expected none", nrise);
        end else begin
          e = sb.pop_front();
          if (e.abort) begin
            check("abort_rd_valid", 64'(nvalid), 64'd0);
          end else begin
            check("mdc_periods", 64'(nrise), 64'(NBITS));
            check("mdio_oe_pattern", cap_oe, e.oe);
            check("mdio_o_bits", cap_o & e.oe, e.bits & e.oe);
            check("busy_len", 64'(blen), 64'(BUSY_LEN));
            check("rd_valid_count", 64'(nvalid), e.rd ? 64'd1 : 64'd0);
            check("rd_data", 64'(bus.rd_data), 64'(e.rd_data));
          end
        end
      end
      mdc_prev = mdc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.wren = 1'b0;
    bus.rden = 1'b0;
    bus.phy_add = '0;
    bus.reg_add = '0;
    bus.wr_data = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("reset_rd_data", 64'(bus.rd_data), 64'd0);
    check("reset_mdc", 64'(mdc), 64'd0);
    check("reset_mdio_o", 64'(mdio_o), 64'd1);
    check("reset_mdio_oe", 64'(mdio_oe), 64'd0);
    mon_en = 1'b1;

    issue(1'b1, 1'b0, 5'd1, 5'd0, 16'h3100, 16'h0, 1'b0);
    wait_done();
    issue(1'b0, 1'b1, 5'd1, 5'd2, 16'h0, 16'h0283, 1'b0);
    wait_done();
    issue(1'b1, 1'b1, 5'd3, 5'd7, 16'hA5C3, 16'hFFFF, 1'b0);
    wait_done();

    // second request during a busy frame must be dropped
    issue(1'b1, 1'b0, 5'd9, 5'd4, 16'h1234, 16'h0, 1'b0);
    repeat (20) @(negedge clk);
    bus.wren = 1'b1;
    bus.rden = 1'b1;
    bus.wr_data = 16'hDEAD;
    @(negedge clk);
    bus.wren = 1'b0;
    bus.rden = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    check("dropped_request_busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      int k = $urandom_range(0, 2);
      issue(k != 1, k != 0, 5'($urandom), 5'($urandom), 16'($urandom),
            16'($urandom), 1'b0);
      wait_done();
    end

    // reset in the middle of a read
    issue(1'b0, 1'b1, 5'd5, 5'd17, 16'h0, 16'h5A5A, 1'b0);
    sb[sb.size() - 1].abort = 1'b1;
    begin
      int   k = 0;
      int   t = 0;
      logic p = 1'b0;
      while (k < ABORT_AT && t < 5000) begin
        @(negedge clk);
        t++;
        if (mdc && !p) k++;
        p = mdc;
      end
      if (t >= 5000) timeout_fail("abort_wait");
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_mdio_oe", 64'(mdio_oe), 64'd0);
    check("abort_mdc", 64'(mdc), 64'd0);
    check("abort_no_valid", 64'(bus.rd_valid), 64'd0);
    check("abort_rd_data", 64'(bus.rd_data), 64'd0);
    rst = 1'b0;
    last_rd = 16'h0;
    @(negedge clk);

    issue(1'b0, 1'b1, 5'd30, 5'd31, 16'h0, 16'hC001, 1'b0);
    wait_done();
    issue(1'b1, 1'b0, 5'd2, 5'd9, 16'h8001, 16'h0, 1'b0);
    wait_done();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
